// File: rtl/stage_sequencer.sv
// Multi-cycle instruction stage sequencer: IF/ID/EX/MEM/WB control FSM with
// stall freeze, memory handshakes, halt state and a retired-instruction counter.
module stage_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        reg_write,
    input  logic        push,
    input  logic        pop,
    input  logic        halt,
    output logic [2:0]  stage,
    output logic        ir_write,
    output logic        pc_write,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        reg_write_en,
    output logic        stack_en,
    output logic        halted,
    output logic [15:0] retired
);

    typedef enum logic [2:0] {
        S_IF   = 3'b000,
        S_ID   = 3'b001,
        S_EX   = 3'b010,
        S_MEM  = 3'b011,
        S_WB   = 3'b100,
        S_HALT = 3'b101
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_retired;
    logic        w_mem_access;
    logic        w_retire;

    assign w_mem_access = mem_read | mem_write;

    // Stall freezes everything; reset wins over stall so a wedged core can always be recovered.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IF;
            r_retired <= 16'h0000;
        end else if (!stall) begin
            r_state <= w_next;
            if (w_retire) begin
                r_retired <= r_retired + 16'd1;
            end
        end
    end

    always_comb begin
        w_next       = r_state;
        w_retire     = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        imem_req     = 1'b0;
        dmem_req     = 1'b0;
        reg_write_en = 1'b0;
        stack_en     = 1'b0;
        halted       = 1'b0;
        case (r_state)
            S_IF: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_write = !stall;
                    w_next   = S_ID;
                end
            end
            S_ID: begin
                w_next = halt ? S_HALT : S_EX;
            end
            S_EX: begin
                // push and pop together still give one strobe; the stack resolves the conflict.
                stack_en = (push | pop) & !stall;
                w_next   = S_MEM;
            end
            S_MEM: begin
                // Request stays decoded from state during a stall so the memory sees a steady request.
                dmem_req = w_mem_access;
                if (!w_mem_access || dmem_ready) begin
                    w_next = S_WB;
                end
            end
            S_WB: begin
                pc_write     = !stall;
                reg_write_en = reg_write & !stall;
                w_retire     = 1'b1;
                w_next       = S_IF;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                w_next = S_IF;
            end
        endcase
    end

    assign stage   = r_state;
    assign retired = r_retired;

endmodule
